fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the 16-point radix-2 DIF FFT datapath. The butterfly pipeline emits its final-stage results in bit-reversed index order. This block absorbs that stream one complex sample per cycle and re-emits each frame in natural frequency order (X[0] … X[15]). It is double-buffered so a new frame can be written while the previous one drains, and it uses valid/ready handshakes on both sides.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_reorder_bank.sv | 34 +++
 rtl/fft_bitrev_reorder.sv | 134 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and the bit-reversal index helper for the FFT output reorder buffer.
package fft_pkg;

    localparam int DEFAULT_SAMPLE_WORD_LENGTH = 8;
    localparam int DEFAULT_LOG2_POINTS        = 4;
    localparam int FFT_POINTS                 = 1 << DEFAULT_LOG2_POINTS;
    localparam int MAX_LOG2                   = 16;

    // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
    function automatic logic [MAX_LOG2-1:0] bitrevN(input logic [MAX_LOG2-1:0] x,
                                                    input int                  width);
        logic [MAX_LOG2-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_LOG2; k++) begin
            if (k < width) begin
                r[k] = x[width-1-k];
            end
        end
        return r;
    endfunction

    function automatic logic [DEFAULT_LOG2_POINTS-1:0] bitrev(input logic [DEFAULT_LOG2_POINTS-1:0] x);
        return DEFAULT_LOG2_POINTS'(bitrevN(MAX_LOG2'(x), DEFAULT_LOG2_POINTS));
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of complex samples: a single write port and an asynchronous read port.
// Contents are deliberately not reset; the control logic never reads an unwritten entry.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int SAMPLE_WORD_LENGTH = DEFAULT_SAMPLE_WORD_LENGTH,
    parameter int LOG2_POINTS        = DEFAULT_LOG2_POINTS
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [LOG2_POINTS-1:0]        wr_addr,
    input  logic [SAMPLE_WORD_LENGTH-1:0] wr_i,
    input  logic [SAMPLE_WORD_LENGTH-1:0] wr_q,
    input  logic [LOG2_POINTS-1:0]        rd_addr,
    output logic [SAMPLE_WORD_LENGTH-1:0] rd_i,
    output logic [SAMPLE_WORD_LENGTH-1:0] rd_q
);

    localparam int POINTS = 1 << LOG2_POINTS;

    logic [SAMPLE_WORD_LENGTH-1:0] memI_q [POINTS];
    logic [SAMPLE_WORD_LENGTH-1:0] memQ_q [POINTS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            memI_q[wr_addr] <= wr_i;
            memQ_q[wr_addr] <= wr_q;
        end
    end

    assign rd_i = memI_q[rd_addr];
    assign rd_q = memQ_q[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Double-buffered reorder stage: frames arrive in bit-reversed order and leave in natural
// frequency order, with independent valid/ready handshakes on the write and read sides.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int SAMPLE_WORD_LENGTH = DEFAULT_SAMPLE_WORD_LENGTH,
    parameter int LOG2_POINTS        = DEFAULT_LOG2_POINTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_WORD_LENGTH-1:0] in_i,
    input  logic [SAMPLE_WORD_LENGTH-1:0] in_q,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SAMPLE_WORD_LENGTH-1:0] out_i,
    output logic [SAMPLE_WORD_LENGTH-1:0] out_q,
    output logic [LOG2_POINTS-1:0]        out_index,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam logic [LOG2_POINTS-1:0] LAST_INDEX = '1;

    logic [1:0]                    full_q, full_d;
    logic                          wBank_q, wBank_d;
    logic                          rBank_q, rBank_d;
    logic [LOG2_POINTS-1:0]        wCnt_q, wCnt_d;
    logic [LOG2_POINTS-1:0]        rCnt_q, rCnt_d;
    logic [SAMPLE_WORD_LENGTH-1:0] outI_q, outI_d;
    logic [SAMPLE_WORD_LENGTH-1:0] outQ_q, outQ_d;
    logic [LOG2_POINTS-1:0]        outIndex_q, outIndex_d;
    logic                          outLast_q, outLast_d;
    logic                          outValid_q, outValid_d;

    logic                          wrFire;
    logic                          rdLoad;
    logic [LOG2_POINTS-1:0]        wrAddr;
    logic [SAMPLE_WORD_LENGTH-1:0] rdI [2];
    logic [SAMPLE_WORD_LENGTH-1:0] rdQ [2];

    // in_ready looks only at registered flags, so out_ready never reaches it combinationally.
    assign in_ready = !full_q[wBank_q];
    assign wrFire   = in_valid && in_ready;
    assign rdLoad   = full_q[rBank_q] && (!outValid_q || out_ready);
    assign wrAddr   = LOG2_POINTS'(bitrevN(MAX_LOG2'(wCnt_q), LOG2_POINTS));

    for (genvar b = 0; b < 2; b++) begin : gBank
        fft_reorder_bank #(
            .SAMPLE_WORD_LENGTH(SAMPLE_WORD_LENGTH),
            .LOG2_POINTS       (LOG2_POINTS)
        ) uBank (
            .clk    (clk),
            .wr_en  (wrFire && (wBank_q == 1'(b))),
            .wr_addr(wrAddr),
            .wr_i   (in_i),
            .wr_q   (in_q),
            .rd_addr(rCnt_q),
            .rd_i   (rdI[b]),
            .rd_q   (rdQ[b])
        );
    end

    // Filling and releasing a bank never target the same flag in one cycle: the writer needs it
    // clear, the reader needs it set, so both updates can be applied unconditionally.
    always_comb begin
        full_d     = full_q;
        wBank_d    = wBank_q;
        rBank_d    = rBank_q;
        wCnt_d     = wCnt_q;
        rCnt_d     = rCnt_q;
        outI_d     = outI_q;
        outQ_d     = outQ_q;
        outIndex_d = outIndex_q;
        outLast_d  = outLast_q;
        outValid_d = outValid_q;

        if (wrFire) begin
            wCnt_d = wCnt_q + 1'b1;
            if (wCnt_q == LAST_INDEX) begin
                full_d[wBank_q] = 1'b1;
                wBank_d         = !wBank_q;
            end
        end

        if (rdLoad) begin
            outI_d     = rdI[rBank_q];
            outQ_d     = rdQ[rBank_q];
            outIndex_d = rCnt_q;
            outLast_d  = (rCnt_q == LAST_INDEX);
            outValid_d = 1'b1;
            rCnt_d     = rCnt_q + 1'b1;
            if (rCnt_q == LAST_INDEX) begin
                full_d[rBank_q] = 1'b0;
                rBank_d         = !rBank_q;
            end
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= '0;
            wBank_q    <= 1'b0;
            rBank_q    <= 1'b0;
            wCnt_q     <= '0;
            rCnt_q     <= '0;
            outI_q     <= '0;
            outQ_q     <= '0;
            outIndex_q <= '0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wBank_q    <= wBank_d;
            rBank_q    <= rBank_d;
            wCnt_q     <= wCnt_d;
            rCnt_q     <= rCnt_d;
            outI_q     <= outI_d;
            outQ_q     <= outQ_d;
            outIndex_q <= outIndex_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_i     = outI_q;
    assign out_q     = outQ_q;
    assign out_index = outIndex_q;
    assign out_last  = outLast_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised bench for fft_bitrev_reorder against a frame-level bit-reversal reference model.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    typedef struct {
        logic [7:0] i;
        logic [7:0] q;
        logic [3:0] idx;
        logic       last;
        int         cyc;
    } obs_t;

    typedef struct {
        logic [7:0] i;
        logic [7:0] q;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_i = '0;
    logic [7:0] in_q = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_i;
    logic [7:0] out_q;
    logic [3:0] out_index;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    obs_t       obsQ[$];
    exp_t       expQ[$];
    logic [7:0] frameI [16];
    logic [7:0] frameQ [16];
    int         framePos = 0;
    int         acceptedCount = 0;
    int         cycleCount = 0;
    int         lastFrameDoneCycle = -1;
    int         firstValidCycle = -1;
    int         stallChecks = 0;
    int         stallViolations = 0;
    logic       prevStall = 1'b0;
    logic [21:0] prevOut = '0;

    logic       snapInReady;
    logic       snapValid;
    logic [7:0] snapI;
    logic [3:0] snapIdx;

    fft_bitrev_reorder dut (
        .clk      (clk),
        .rst      (rst),
        .in_i     (in_i),
        .in_q     (in_q),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_index(out_index),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock cycle: drive at the falling edge, record what the next rising edge will accept.
    task automatic cycle(input logic iv, input logic [7:0] di, input logic [7:0] dq, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_i      = di;
        in_q      = dq;
        out_ready = ordy;
        snapInReady = in_ready;
        snapValid   = out_valid;
        snapI       = out_i;
        snapIdx     = out_index;
        if (prevStall) begin
            stallChecks++;
            if ({out_i, out_q, out_index, out_last, out_valid} !== prevOut) stallViolations++;
        end
        prevStall = out_valid && !ordy;
        prevOut   = {out_i, out_q, out_index, out_last, out_valid};
        if (out_valid && firstValidCycle < 0) firstValidCycle = cycleCount;
        if (iv && in_ready) begin
            acceptedCount++;
            frameI[framePos] = di;
            frameQ[framePos] = dq;
            framePos++;
            if (framePos == 16) begin
                // Natural index k was delivered at input position bitrev(k).
                for (int k = 0; k < 16; k++) begin
                    exp_t e;
                    e.i   = frameI[bitrev(4'(k))];
                    e.q   = frameQ[bitrev(4'(k))];
                    e.idx = 4'(k);
                    expQ.push_back(e);
                end
                framePos = 0;
                lastFrameDoneCycle = cycleCount;
            end
        end
        if (out_valid && ordy) begin
            obs_t o;
            o.i = out_i; o.q = out_q; o.idx = out_index; o.last = out_last; o.cyc = cycleCount;
            obsQ.push_back(o);
        end
        cycleCount++;
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        obsQ.delete();
        expQ.delete();
        framePos = 0;
        acceptedCount = 0;
        firstValidCycle = -1;
        lastFrameDoneCycle = -1;
        prevStall = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_i, out_q, out_index, out_last} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b i=%h q=%h idx=%0d last=%b, want all zero",
                     out_valid, out_i, out_q, out_index, out_last);
        end
        doReset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, want 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_frame();
        int orderTab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int guard = 0;
        doReset();
        for (int m = 0; m < 16; m++) cycle(1'b1, 8'(m), 8'(-m), 1'b1);
        while (obsQ.size() < 16 && guard < 100) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1);
            guard++;
        end
        checks++;
        if (firstValidCycle - lastFrameDoneCycle !== 2) begin
            errors++;
            $display("[TB] FAIL single_latency: first valid %0d cycles after last input, want 2",
                     firstValidCycle - lastFrameDoneCycle);
        end
        checks++;
        if (obsQ.size() !== 16) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d outputs, want 16", obsQ.size());
        end
        for (int k = 0; k < 16 && k < obsQ.size(); k++) begin
            checks++;
            if (obsQ[k].i !== 8'(orderTab[k]) || obsQ[k].q !== 8'(-orderTab[k]) ||
                obsQ[k].idx !== 4'(k) || obsQ[k].last !== (k == 15)) begin
                errors++;
                $display("[TB] FAIL single_order[%0d]: got i=%0d q=%h idx=%0d last=%b, want i=%0d q=%h idx=%0d last=%b",
                         k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, obsQ[k].last,
                         orderTab[k], 8'(-orderTab[k]), k, (k == 15));
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        int lowCount = 0;
        int gaps = 0;
        doReset();
        for (int n = 0; n < 48; n++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
            if (snapInReady !== 1'b1) lowCount++;
        end
        while (obsQ.size() < 48 && guard < 100) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1);
            guard++;
        end
        checks++;
        if (lowCount !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready: low for %0d cycles, want 0", lowCount);
        end
        checks++;
        if (obsQ.size() !== 48) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d outputs, want 48", obsQ.size());
        end
        for (int k = 1; k < obsQ.size(); k++) if (obsQ[k].cyc !== obsQ[0].cyc + k) gaps++;
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_contiguous: %0d gaps in output stream, want 0", gaps);
        end
        for (int k = 0; k < obsQ.size() && k < expQ.size(); k++) begin
            checks++;
            if (obsQ[k].i !== expQ[k].i || obsQ[k].q !== expQ[k].q ||
                obsQ[k].idx !== expQ[k].idx || obsQ[k].last !== (expQ[k].idx == 4'd15)) begin
                errors++;
                $display("[TB] FAIL b2b_data[%0d]: got i=%h q=%h idx=%0d last=%b, want i=%h q=%h idx=%0d",
                         k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, obsQ[k].last, expQ[k].i, expQ[k].q, expQ[k].idx);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        logic prevReady;
        logic seenLast = 1'b0;
        doReset();
        for (int n = 0; n < 40; n++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        checks++;
        if (acceptedCount !== 32) begin
            errors++;
            $display("[TB] FAIL bp_accepted: got %0d samples accepted, want 32", acceptedCount);
        end
        checks++;
        if (snapInReady !== 1'b0 || snapValid !== 1'b1 || snapIdx !== 4'd0 || snapI !== expQ[0].i) begin
            errors++;
            $display("[TB] FAIL bp_hold: in_ready=%b valid=%b idx=%0d i=%h, want 0 1 0 %h",
                     snapInReady, snapValid, snapIdx, snapI, expQ[0].i);
        end
        prevReady = snapInReady;
        while (obsQ.size() < 32 && guard < 200) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1);
            guard++;
            if (!seenLast && snapValid && snapIdx == 4'd15) begin
                seenLast = 1'b1;
                checks++;
                if (prevReady !== 1'b0 || snapInReady !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bp_ready_rise: in_ready before/at index 15 = %b/%b, want 0/1",
                             prevReady, snapInReady);
                end
            end
            prevReady = snapInReady;
        end
        checks++;
        if (obsQ.size() !== 32 || !seenLast) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d outputs (index 15 seen=%b), want 32", obsQ.size(), seenLast);
        end
        for (int k = 0; k < obsQ.size() && k < expQ.size(); k++) begin
            checks++;
            if (obsQ[k].i !== expQ[k].i || obsQ[k].q !== expQ[k].q ||
                obsQ[k].idx !== expQ[k].idx || obsQ[k].last !== (expQ[k].idx == 4'd15)) begin
                errors++;
                $display("[TB] FAIL bp_data[%0d]: got i=%h q=%h idx=%0d, want i=%h q=%h idx=%0d",
                         k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, expQ[k].i, expQ[k].q, expQ[k].idx);
            end
        end
    endtask

    task automatic test_random();
        int guard = 0;
        int bad = 0;
        doReset();
        stallChecks = 0;
        stallViolations = 0;
        while (acceptedCount < 320 && guard < 5000) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            guard++;
        end
        guard = 0;
        while (obsQ.size() < 320 && guard < 2000) begin
            cycle(1'b0, 8'd0, 8'd0, 1'($urandom_range(0, 3) != 0));
            guard++;
        end
        checks++;
        if (obsQ.size() !== 320 || expQ.size() !== 320) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d outputs, model %0d, want 320", obsQ.size(), expQ.size());
        end
        checks++;
        if (stallViolations !== 0 || stallChecks == 0) begin
            errors++;
            $display("[TB] FAIL rand_stall_stable: %0d changes over %0d stalled cycles, want 0 changes",
                     stallViolations, stallChecks);
        end
        for (int k = 0; k < obsQ.size() && k < expQ.size(); k++) begin
            if (obsQ[k].i !== expQ[k].i || obsQ[k].q !== expQ[k].q ||
                obsQ[k].idx !== expQ[k].idx || obsQ[k].last !== (expQ[k].idx == 4'd15)) begin
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL rand_data[%0d]: got i=%h q=%h idx=%0d, want i=%h q=%h idx=%0d",
                             k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, expQ[k].i, expQ[k].q, expQ[k].idx);
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL rand_data_total: %0d mismatching outputs, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        doReset();
        for (int n = 0; n < 16; n++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        for (int n = 0; n < 7; n++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_i, out_q, out_index, out_last} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got valid=%b i=%h q=%h idx=%0d last=%b, want all zero",
                     out_valid, out_i, out_q, out_index, out_last);
        end
        doReset();
        for (int n = 0; n < 16; n++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        while (guard < 40) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1);
            guard++;
        end
        checks++;
        if (obsQ.size() !== 16) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d outputs after reset, want 16", obsQ.size());
        end
        for (int k = 0; k < obsQ.size() && k < expQ.size(); k++) begin
            checks++;
            if (obsQ[k].i !== expQ[k].i || obsQ[k].q !== expQ[k].q || obsQ[k].idx !== expQ[k].idx) begin
                errors++;
                $display("[TB] FAIL midreset_data[%0d]: got i=%h q=%h idx=%0d, want i=%h q=%h idx=%0d",
                         k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, expQ[k].i, expQ[k].q, expQ[k].idx);
            end
        end
    endtask

    task automatic test_extremes();
        int guard = 0;
        doReset();
        for (int m = 0; m < 16; m++) begin
            logic [3:0] mb;
            mb = 4'(m);
            cycle(1'b1, mb[0] ? 8'h80 : 8'h7F, mb[1] ? 8'h7F : 8'h80, 1'b1);
        end
        while (obsQ.size() < 16 && guard < 100) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1);
            guard++;
        end
        checks++;
        if (obsQ.size() !== 16) begin
            errors++;
            $display("[TB] FAIL extremes_count: got %0d outputs, want 16", obsQ.size());
        end
        for (int k = 0; k < obsQ.size() && k < expQ.size(); k++) begin
            checks++;
            if (obsQ[k].i !== expQ[k].i || obsQ[k].q !== expQ[k].q || obsQ[k].idx !== expQ[k].idx) begin
                errors++;
                $display("[TB] FAIL extremes_data[%0d]: got i=%h q=%h idx=%0d, want i=%h q=%h idx=%0d",
                         k, obsQ[k].i, obsQ[k].q, obsQ[k].idx, expQ[k].i, expQ[k].q, expQ[k].idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
